// File: rtl/cart_mem_arbiter.sv
// Serialises mapped PRG/CHR accesses onto one single-port cart memory with a
// one-deep slot per source, alternating tie-break, read-data hold and a wait timeout.
module cart_mem_arbiter #(
    parameter int AW       = 22,
    parameter int WAIT_MAX = 31
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          prg_req,
    input  logic [AW-1:0] prg_addr,
    input  logic          prg_we,
    input  logic [7:0]    prg_wdata,
    input  logic          prg_allow,
    output logic [7:0]    prg_rdata,
    output logic          prg_done,
    input  logic          chr_req,
    input  logic [AW-1:0] chr_addr,
    input  logic          chr_we,
    input  logic [7:0]    chr_wdata,
    input  logic          chr_allow,
    output logic [7:0]    chr_rdata,
    output logic          chr_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic          overrun,
    output logic          timeout_err,
    output logic [1:0]    dbg_state
);
    // Memory handshake: mem_rd/mem_wr is a one-cycle command with mem_addr/mem_wdata
    // stable; the access completes on the single cycle mem_ack is high while in WAIT.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
    localparam logic PRG = 1'b0;
    localparam logic CHR = 1'b1;

    state_t             state_q, state_d;
    logic               last_q, last_d;     // last granted side, also the side in flight
    logic               cur_we_q, cur_we_d;
    logic               flush_q, flush_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [1:0]         vld_q, vld_d;
    logic [1:0][AW-1:0] addr_q, addr_d;
    logic [1:0]         we_q, we_d;
    logic [1:0][7:0]    wd_q, wd_d;
    logic [1:0][7:0]    rdata_q, rdata_d;
    logic [1:0]         done_q, done_d;
    logic [AW-1:0]      maddr_q, maddr_d;
    logic [7:0]         mwd_q, mwd_d;
    logic               ovr_q, ovr_d;
    logic               tmo_q, tmo_d;

    logic [1:0]         req_v, allow_v, we_v;
    logic [1:0][AW-1:0] addr_v;
    logic [1:0][7:0]    wd_v;
    logic               ack_fin, tmo_fin, keep, gnt;

    assign req_v   = {chr_req, prg_req};
    assign allow_v = {chr_allow, prg_allow};
    assign we_v    = {chr_we, prg_we};
    assign addr_v  = {chr_addr, prg_addr};
    assign wd_v    = {chr_wdata, prg_wdata};

    assign ack_fin = (state_q == S_WAIT) && mem_ack;
    assign tmo_fin = (state_q == S_WAIT) && !mem_ack && (cnt_q == 5'(WAIT_MAX - 1));
    // A completion seen while flushed (or with enable low) is swallowed silently.
    assign keep    = (ack_fin || tmo_fin) && enable && !flush_q;
    assign gnt     = (vld_q[PRG] && vld_q[CHR]) ? ~last_q : vld_q[CHR];

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cur_we_d = cur_we_q;
        flush_d  = flush_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wd_d     = wd_q;
        rdata_d  = rdata_q;
        done_d   = 2'b00;
        maddr_d  = maddr_q;
        mwd_d    = mwd_q;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;

        case (state_q)
            S_IDLE: begin
                flush_d = 1'b0;
                if (enable && (vld_q != 2'b00)) begin
                    last_d   = gnt;
                    cur_we_d = we_q[gnt];
                    maddr_d  = addr_q[gnt];
                    mwd_d    = wd_q[gnt];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 5'd0;
                state_d = enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!enable) flush_d = 1'b1;
                if (ack_fin || tmo_fin) begin
                    state_d = S_IDLE;
                    if (tmo_fin) tmo_d = 1'b1;
                    if (keep) begin
                        done_d[last_q] = 1'b1;
                        vld_d[last_q]  = 1'b0;
                        if (!cur_we_q) rdata_d[last_q] = ack_fin ? mem_rdata : 8'hFF;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) vld_d = 2'b00;

        // Capture after completion so a slot freed this cycle can take a new request.
        for (int s = 0; s < 2; s++) begin
            if (req_v[s] && enable) begin
                if (vld_d[s]) begin
                    ovr_d = 1'b1;
                end else if (allow_v[s]) begin
                    vld_d[s]  = 1'b1;
                    addr_d[s] = addr_v[s];
                    we_d[s]   = we_v[s];
                    wd_d[s]   = wd_v[s];
                end else begin
                    done_d[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            last_q   <= PRG;
            cur_we_q <= 1'b0;
            flush_q  <= 1'b0;
            cnt_q    <= 5'd0;
            vld_q    <= 2'b00;
            addr_q   <= '0;
            we_q     <= 2'b00;
            wd_q     <= '0;
            rdata_q  <= {8'hFF, 8'hFF};
            done_q   <= 2'b00;
            maddr_q  <= '0;
            mwd_q    <= 8'h00;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cur_we_q <= cur_we_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wd_q     <= wd_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            maddr_q  <= maddr_d;
            mwd_q    <= mwd_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign mem_rd      = (state_q == S_ISSUE) && enable && !cur_we_q;
    assign mem_wr      = (state_q == S_ISSUE) && enable && cur_we_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = mwd_q;
    assign prg_rdata   = rdata_q[PRG];
    assign chr_rdata   = rdata_q[CHR];
    assign prg_done    = done_q[PRG];
    assign chr_done    = done_q[CHR];
    assign overrun     = ovr_q;
    assign timeout_err = tmo_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter: expected memory commands and done responses
// are queued at stimulus time and popped by a negedge monitor.
module tb_cart_mem_arbiter;
  localparam int AW = 22;
  localparam logic [31:0] DC = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset_n, enable;
  logic          prg_req, prg_we, prg_allow, prg_done;
  logic [AW-1:0] prg_addr;
  logic [7:0]    prg_wdata, prg_rdata;
  logic          chr_req, chr_we, chr_allow, chr_done;
  logic [AW-1:0] chr_addr;
  logic [7:0]    chr_wdata, chr_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr, mem_ack;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          overrun, timeout_err;
  logic [1:0]    dbg_state;

  cart_mem_arbiter #(.AW(AW), .WAIT_MAX(31)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .prg_req(prg_req), .prg_addr(prg_addr), .prg_we(prg_we), .prg_wdata(prg_wdata),
    .prg_allow(prg_allow), .prg_rdata(prg_rdata), .prg_done(prg_done),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_we(chr_we), .chr_wdata(chr_wdata),
    .chr_allow(chr_allow), .chr_rdata(chr_rdata), .chr_done(chr_done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .overrun(overrun), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [7:0] wdata; logic [31:0] cyc;} mem_exp_t;
  typedef struct packed {logic [7:0] rdata; logic [31:0] cyc;} done_exp_t;
  mem_exp_t  mem_exp_q[$];
  done_exp_t prg_exp_q[$];
  done_exp_t chr_exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int ack_lat = 1;
  logic [7:0] resp_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_mem(input logic wr, input logic [AW-1:0] a, input logic [7:0] wd, input logic [31:0] c);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.wdata = wd; e.cyc = c;
    mem_exp_q.push_back(e);
  endtask

  task automatic push_done(input logic chr, input logic [7:0] rd, input logic [31:0] c);
    done_exp_t e;
    e.rdata = rd; e.cyc = c;
    if (chr) chr_exp_q.push_back(e);
    else prg_exp_q.push_back(e);
  endtask

  // monitor + memory responder
  task automatic mon_resp();
    int ack_cnt = 0;
    mem_exp_t  me;
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_rd || mem_wr) begin
          check("mem_rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
          if (mem_exp_q.size() == 0) fail_now("unexpected_mem_cmd");
          else begin
            me = mem_exp_q.pop_front();
            check("mem_wr", {31'd0, mem_wr}, {31'd0, me.wr});
            check("mem_addr", {10'd0, mem_addr}, {10'd0, me.addr});
            if (me.wr) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, me.wdata});
            if (me.cyc != DC) check("mem_cmd_cycle", cyc, me.cyc);
          end
        end
        if (prg_done) begin
          if (prg_exp_q.size() == 0) fail_now("unexpected_prg_done");
          else begin
            de = prg_exp_q.pop_front();
            check("prg_rdata_at_done", {24'd0, prg_rdata}, {24'd0, de.rdata});
            if (de.cyc != DC) check("prg_done_cycle", cyc, de.cyc);
          end
        end
        if (chr_done) begin
          if (chr_exp_q.size() == 0) fail_now("unexpected_chr_done");
          else begin
            de = chr_exp_q.pop_front();
            check("chr_rdata_at_done", {24'd0, chr_rdata}, {24'd0, de.rdata});
            if (de.cyc != DC) check("chr_done_cycle", cyc, de.cyc);
          end
        end
      end
      mem_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = resp_data;
        end
      end else if (reset_n && (mem_rd || mem_wr) && ack_lat > 0) begin
        ack_cnt = ack_lat;
      end
    end
  endtask

  // driver tasks
  task automatic set_req(input logic chr, input logic [AW-1:0] a, input logic we,
                         input logic [7:0] wd, input logic allow);
    if (chr) begin
      chr_req = 1'b1; chr_addr = a; chr_we = we; chr_wdata = wd; chr_allow = allow;
    end else begin
      prg_req = 1'b1; prg_addr = a; prg_we = we; prg_wdata = wd; prg_allow = allow;
    end
  endtask

  task automatic tick_clear();
    @(posedge clk); #1;
    prg_req = 1'b0;
    chr_req = 1'b0;
  endtask

  task automatic edge_sync(output int c);
    @(posedge clk); #1;
    c = cyc;
  endtask

  task automatic wait_state(input logic [1:0] st, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (dbg_state == st) break;
    end
    if (i >= max) fail_now("wait_state_timeout");
  endtask

  task automatic wait_mem_cmd(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (mem_rd || mem_wr) break;
    end
    if (i >= max) fail_now("wait_mem_cmd_timeout");
  endtask

  task automatic drain(input int max);
    int i = 0;
    while ((mem_exp_q.size() != 0 || prg_exp_q.size() != 0 || chr_exp_q.size() != 0 ||
            dbg_state != 2'd0) && i < max) begin
      @(negedge clk);
      i++;
    end
    if (i >= max) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_prg_rdata"}, {24'd0, prg_rdata}, 32'hFF);
    check({tag, "_chr_rdata"}, {24'd0, chr_rdata}, 32'hFF);
    check({tag, "_dones"}, {30'd0, prg_done, chr_done}, 32'd0);
    check({tag, "_mem_cmd"}, {30'd0, mem_rd, mem_wr}, 32'd0);
    check({tag, "_mem_addr"}, {10'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_flags"}, {30'd0, overrun, timeout_err}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic run_tests();
    int a;
    reset_n = 1'b0; enable = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
    prg_req = 0; prg_addr = '0; prg_we = 0; prg_wdata = 0; prg_allow = 0;
    chr_req = 0; chr_addr = '0; chr_we = 0; chr_wdata = 0; chr_allow = 0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: single PRG read, latency and hold
    ack_lat = 1; resp_data = 8'h5A;
    edge_sync(a);
    push_mem(1'b0, 22'h00A123, 8'h00, a + 2);
    push_done(1'b0, 8'h5A, a + 4);
    set_req(1'b0, 22'h00A123, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(40);
    repeat (5) @(negedge clk);
    check("prg_rdata_hold", {24'd0, prg_rdata}, 32'h5A);

    // 2: tie after reset goes to CHR, then PRG
    resp_data = 8'h3C;
    edge_sync(a);
    push_mem(1'b0, 22'h100200, 8'h00, DC);
    push_mem(1'b0, 22'h000040, 8'h00, DC);
    push_done(1'b1, 8'h3C, DC);
    push_done(1'b0, 8'h3C, DC);
    set_req(1'b1, 22'h100200, 1'b0, 8'h00, 1'b1);
    set_req(1'b0, 22'h000040, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(40);
    // lone CHR write leaves last_grant on CHR; chr_rdata unchanged by a write
    edge_sync(a);
    push_mem(1'b1, 22'h100300, 8'hA5, DC);
    push_done(1'b1, 8'h3C, DC);
    set_req(1'b1, 22'h100300, 1'b1, 8'hA5, 1'b1);
    tick_clear();
    drain(40);
    // next tie goes to PRG
    resp_data = 8'h4D;
    edge_sync(a);
    push_mem(1'b0, 22'h000050, 8'h00, DC);
    push_mem(1'b0, 22'h100250, 8'h00, DC);
    push_done(1'b0, 8'h4D, DC);
    push_done(1'b1, 8'h4D, DC);
    set_req(1'b1, 22'h100250, 1'b0, 8'h00, 1'b1);
    set_req(1'b0, 22'h000050, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(40);

    // 3: denied CHR write -> done next cycle, no memory command
    edge_sync(a);
    push_done(1'b1, 8'h4D, a + 1);
    set_req(1'b1, 22'h21F000, 1'b1, 8'h77, 1'b0);
    tick_clear();
    drain(20);
    check("chr_rdata_after_deny", {24'd0, chr_rdata}, 32'h4D);

    // 4a: request in the ack cycle is accepted without overrun
    ack_lat = 1; resp_data = 8'h5B;
    edge_sync(a);
    push_mem(1'b0, 22'h000100, 8'h00, DC);
    push_mem(1'b0, 22'h000300, 8'h00, DC);
    push_done(1'b0, 8'h5B, DC);
    push_done(1'b0, 8'h5B, DC);
    set_req(1'b0, 22'h000100, 1'b0, 8'h00, 1'b1);
    tick_clear();
    wait_mem_cmd(20);
    @(posedge clk); #1;
    set_req(1'b0, 22'h000300, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(40);
    check("overrun_ack_cycle", {31'd0, overrun}, 32'd0);
    check("timeout_err_clear", {31'd0, timeout_err}, 32'd0);

    // 4b: request while in WAIT is dropped and flags overrun
    ack_lat = 3; resp_data = 8'h6E;
    edge_sync(a);
    push_mem(1'b0, 22'h000110, 8'h00, DC);
    push_done(1'b0, 8'h6E, DC);
    set_req(1'b0, 22'h000110, 1'b0, 8'h00, 1'b1);
    tick_clear();
    wait_state(2'd2, 20);
    @(posedge clk); #1;
    set_req(1'b0, 22'h000210, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(40);
    check("overrun_set", {31'd0, overrun}, 32'd1);

    // 5: withheld ack -> timeout after 31 WAIT cycles, then normal access
    ack_lat = 0;
    edge_sync(a);
    push_mem(1'b0, 22'h000400, 8'h00, DC);
    push_done(1'b0, 8'hFF, a + 34);
    set_req(1'b0, 22'h000400, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(80);
    check("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    ack_lat = 1; resp_data = 8'h99;
    edge_sync(a);
    push_mem(1'b0, 22'h000500, 8'h00, DC);
    push_done(1'b0, 8'h99, a + 4);
    set_req(1'b0, 22'h000500, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(40);

    // 6a: asynchronous reset during WAIT
    ack_lat = 0;
    edge_sync(a);
    push_mem(1'b0, 22'h000600, 8'h00, DC);
    set_req(1'b0, 22'h000600, 1'b0, 8'h00, 1'b1);
    tick_clear();
    wait_state(2'd2, 20);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 6b: enable low in WAIT, ack later -> no done, back to IDLE
    ack_lat = 4; resp_data = 8'h42;
    edge_sync(a);
    push_mem(1'b0, 22'h000700, 8'h00, DC);
    set_req(1'b0, 22'h000700, 1'b0, 8'h00, 1'b1);
    tick_clear();
    wait_state(2'd2, 20);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("flush_state_idle", {30'd0, dbg_state}, 32'd0);
    check("flush_prg_rdata", {24'd0, prg_rdata}, 32'hFF);
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    ack_lat = 1; resp_data = 8'h24;
    edge_sync(a);
    push_mem(1'b0, 22'h100800, 8'h00, DC);
    push_done(1'b1, 8'h24, a + 4);
    set_req(1'b1, 22'h100800, 1'b0, 8'h00, 1'b1);
    tick_clear();
    drain(40);

    check("mem_exp_q_empty", mem_exp_q.size(), 32'd0);
    check("prg_exp_q_empty", prg_exp_q.size(), 32'd0);
    check("chr_exp_q_empty", chr_exp_q.size(), 32'd0);
  endtask

  // report
  initial begin
    fork
      mon_resp();
      run_tests();
      begin
        #2_000_000;
        fail_now("global_watchdog");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
